pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl_if.sv | 39 +++
 rtl/pipeline_ctrl_load_use_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for pipeline_ctrl: sequencer states, default timing constants
// and the bundle of pipeline-register control bits driven each cycle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  localparam int DEF_MEM_TIMEOUT  = 16;
  localparam int DEF_DRAIN_CYCLES = 4;

  typedef struct packed {
    logic pc_write;
    logic pc_sel_branch;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } pipe_ctl_t;

  // Everything held, nothing squashed.
  localparam pipe_ctl_t CTL_IDLE    = pipe_ctl_t'(8'b0000_0000);
  // Every register and the PC load their next value, nothing squashed.
  localparam pipe_ctl_t CTL_ADVANCE = pipe_ctl_t'(8'b1010_1010);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the 5-stage
// datapath (master) and the stall/flush sequencer (slave).
interface pipeline_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       mem_access;
  logic       mem_ready;
  logic       halt_req;

  logic       pc_write;
  logic       pc_sel_branch;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_flush;
  logic       ex_mem_write;
  logic       mem_wb_flush;
  logic       freeze;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_access, mem_ready, halt_req,
    input  pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, mem_wb_flush, freeze
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_memread, ex_branch_taken,
           mem_access, mem_ready, halt_req,
    output pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, mem_wb_flush, freeze
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction
// reads. x0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority mux, RUN/DRAIN/HALTED
// FSM and memory timeout. Performance counters exist only with PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   pif,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int             WW   = $clog2(MEM_TIMEOUT);
  localparam int             DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WW-1:0]  WMAX = WW'(MEM_TIMEOUT - 1);
  localparam logic [DW-1:0]  DMAX = DW'(DRAIN_CYCLES - 1);

  pipe_state_e   state;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] dcnt;
  pipe_ctl_t     ctl;
  logic          load_use;
  logic          mem_stall;
  logic          freeze_now;

  load_use_detect u_load_use (
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_uses_rs2 (pif.id_uses_rs2),
    .ex_rd       (pif.ex_rd),
    .ex_memread  (pif.ex_memread),
    .load_use    (load_use)
  );

  assign mem_stall = pif.mem_access && !pif.mem_ready;

  // First matching condition wins; a held pipeline keeps deferred hazards visible.
  always_comb begin
    ctl        = CTL_IDLE;
    freeze_now = 1'b0;
    if (rst) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_flush  = 1'b1;
      ctl.mem_wb_flush = 1'b1;
    end else if (state == HALTED) begin
      ctl = CTL_IDLE;
    end else if (mem_stall) begin
      ctl.mem_wb_flush = 1'b1;
      freeze_now       = 1'b1;
    end else if (pif.ex_branch_taken) begin
      ctl               = CTL_ADVANCE;
      ctl.pc_write      = (state == RUN);
      ctl.pc_sel_branch = (state == RUN);
      ctl.if_id_flush   = 1'b1;
      ctl.id_ex_flush   = 1'b1;
    end else if (load_use) begin
      ctl             = CTL_ADVANCE;
      ctl.pc_write    = 1'b0;
      ctl.if_id_write = 1'b0;
      ctl.id_ex_flush = 1'b1;
    end else if (pif.halt_req || (state == DRAIN)) begin
      ctl             = CTL_ADVANCE;
      ctl.pc_write    = 1'b0;
      ctl.if_id_flush = 1'b1;
    end else begin
      ctl = CTL_ADVANCE;
    end
  end

  assign pif.pc_write      = ctl.pc_write;
  assign pif.pc_sel_branch = ctl.pc_sel_branch;
  assign pif.if_id_write   = ctl.if_id_write;
  assign pif.if_id_flush   = ctl.if_id_flush;
  assign pif.id_ex_write   = ctl.id_ex_write;
  assign pif.id_ex_flush   = ctl.id_ex_flush;
  assign pif.ex_mem_write  = ctl.ex_mem_write;
  assign pif.mem_wb_flush  = ctl.mem_wb_flush;
  assign pif.freeze        = freeze_now;

  assign halted = (state == HALTED);

  // Drain progress pauses while memory freezes; a halt loses to branch and load-use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wcnt        <= '0;
      dcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (state != HALTED) begin
      if (mem_stall) begin
        wcnt <= wcnt + WW'(1);
        if (wcnt == WMAX) begin
          state       <= HALTED;
          timeout_err <= 1'b1;
        end
      end else begin
        wcnt <= '0;
        if (state == DRAIN) begin
          if (dcnt == DMAX) begin
            state <= HALTED;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end else if (pif.halt_req && !pif.ex_branch_taken && !load_use) begin
          state <= DRAIN;
          dcnt  <= '0;
        end
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counters, frozen once the pipeline has stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      cycle_cnt <= '0;
    end else if (state != HALTED) begin
      if (cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if ((mem_stall || (!pif.ex_branch_taken && load_use)) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!mem_stall && pif.ex_branch_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl (MEM_TIMEOUT=4, DRAIN_CYCLES=4): a table of single-cycle
// hazard vectors, then hand-written stall, drain, reset and timeout sequences.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // Expected {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
  //           id_ex_flush, ex_mem_write, mem_wb_flush, freeze}
  localparam logic [8:0] E_RUN = 9'b1_0101_0100;
  localparam logic [8:0] E_BR  = 9'b1_1111_1100;
  localparam logic [8:0] E_LU  = 9'b0_0001_1100;
  localparam logic [8:0] E_FRZ = 9'b0_0000_0011;
  localparam logic [8:0] E_DRN = 9'b0_0111_0100;
  localparam logic [8:0] E_RST = 9'b0_0010_1010;
  localparam logic [8:0] E_HLT = 9'b0_0000_0000;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic [4:0] rd;
    logic       memread;
    logic       br;
    logic       macc;
    logic       mrdy;
    logic       halt;
    logic [8:0] ctl;
    logic       hlt;
    logic       terr;
    logic       st;
    logic       fl;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  int               n_vec = 0;
  int               n_err = 0;
  logic [10:0]      sb_q[$];
  int unsigned      e_st = 0, e_fl = 0, e_cy = 0;
  bit               pend_rst = 1'b1, pend_cy = 1'b0, pend_st = 1'b0, pend_fl = 1'b0;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(
    .MEM_TIMEOUT  (4),
    .DRAIN_CYCLES (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pif         (pif),
    .halted      (halted),
    .timeout_err (timeout_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic mr, logic br, logic macc,
                              logic mrdy, logic halt, logic [8:0] ctl, logic hlt,
                              logic terr, logic st, logic fl);
    vec_t v;
    v.rst = r;  v.rs1 = rs1; v.rs2 = rs2; v.uses2 = u2; v.rd = rd;
    v.memread = mr; v.br = br; v.macc = macc; v.mrdy = mrdy; v.halt = halt;
    v.ctl = ctl; v.hlt = hlt; v.terr = terr; v.st = st; v.fl = fl;
    return v;
  endfunction

  task automatic checkOutput(input string tag);
    logic [10:0] exp_v;
    logic [10:0] act_v;
    exp_v = sb_q.pop_front();
    act_v = {pif.pc_write, pif.pc_sel_branch, pif.if_id_write, pif.if_id_flush,
             pif.id_ex_write, pif.id_ex_flush, pif.ex_mem_write, pif.mem_wb_flush,
             pif.freeze, halted, timeout_err};
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: ctl/freeze/halted/terr got %b expected %b", tag, act_v, exp_v);
    end
  endtask

  task automatic checkVal(input string tag, input logic [CNT_W-1:0] act,
                          input logic [CNT_W-1:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; the next rising edge commits them.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    if (pend_rst) begin
      e_st = 0; e_fl = 0; e_cy = 0;
    end else begin
      e_cy += pend_cy; e_st += pend_st; e_fl += pend_fl;
    end
    pend_rst = v.rst;
    pend_cy  = !v.rst && !v.hlt;
    pend_st  = v.st;
    pend_fl  = v.fl;
    rst                 = v.rst;
    pif.id_rs1          = v.rs1;
    pif.id_rs2          = v.rs2;
    pif.id_uses_rs2     = v.uses2;
    pif.ex_rd           = v.rd;
    pif.ex_memread      = v.memread;
    pif.ex_branch_taken = v.br;
    pif.mem_access      = v.macc;
    pif.mem_ready       = v.mrdy;
    pif.halt_req        = v.halt;
    sb_q.push_back({v.ctl, v.hlt, v.terr});
    #2;
    checkOutput(tag);
  endtask

  task automatic checkCounters(input string tag);
    int unsigned es, ef, ec;
`ifdef PIPE_PERF_CNT_EN
    es = e_st; ef = e_fl; ec = e_cy;
`else
    es = 0; ef = 0; ec = 0;
`endif
    checkVal({tag, " stall_cnt"}, stall_cnt, es);
    checkVal({tag, " flush_cnt"}, flush_cnt, ef);
    checkVal({tag, " cycle_cnt"}, cycle_cnt, ec);
  endtask

  initial begin
    vec_t tbl [0:13];
    vec_t idle, frz, halt, drn, hltd, rstv;

    rst = 1'b1;
    pif.id_rs1 = '0; pif.id_rs2 = '0; pif.id_uses_rs2 = 1'b0; pif.ex_rd = '0;
    pif.ex_memread = 1'b0; pif.ex_branch_taken = 1'b0; pif.mem_access = 1'b0;
    pif.mem_ready = 1'b1; pif.halt_req = 1'b0;
    repeat (2) @(posedge clk);

    //           rst rs1 rs2 u2 rd mr br ma rdy hlt ctl   H  T  st fl
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_RST, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);
    tbl[2]  = mk(0, 5, 1, 0, 5, 1, 0, 0, 1, 0, E_LU,  0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);
    tbl[4]  = mk(0, 3, 7, 1, 7, 1, 0, 0, 1, 0, E_LU,  0, 0, 1, 0);
    tbl[5]  = mk(0, 3, 7, 0, 7, 1, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);
    tbl[6]  = mk(0, 5, 1, 0, 5, 0, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);
    tbl[7]  = mk(0, 5, 1, 0, 5, 1, 1, 0, 1, 0, E_BR,  0, 0, 0, 1);
    tbl[8]  = mk(0, 1, 2, 1, 3, 0, 1, 0, 1, 1, E_BR,  0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 2, 1, 3, 0, 1, 1, 0, 0, E_FRZ, 0, 0, 1, 0);
    tbl[10] = mk(0, 1, 2, 1, 3, 0, 0, 1, 1, 0, E_RUN, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 2, 1, 3, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0, 0);
    tbl[12] = mk(0, 5, 1, 0, 5, 1, 0, 0, 1, 1, E_LU,  0, 0, 1, 0);
    tbl[13] = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end
    checkCounters("table");

    idle = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RUN, 0, 0, 0, 0);
    frz  = mk(0, 1, 2, 1, 3, 0, 0, 1, 0, 0, E_FRZ, 0, 0, 1, 0);
    halt = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 1, E_DRN, 0, 0, 0, 0);
    drn  = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_DRN, 0, 0, 0, 0);
    hltd = mk(0, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_HLT, 1, 0, 0, 0);
    rstv = mk(1, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RST, 0, 0, 0, 0);

    // Three not-ready cycles, released on the ready edge.
    for (int i = 0; i < 3; i++) applyStimulus(frz, $sformatf("memstall%0d", i));
    applyStimulus(mk(0, 1, 2, 1, 3, 0, 0, 1, 1, 0, E_RUN, 0, 0, 0, 0), "memstall_release");
    checkCounters("memstall");

    // Halt, then a drain with one freeze: halted visible six edges after halt_req.
    applyStimulus(halt, "halt_req");
    applyStimulus(drn, "drain0");
    applyStimulus(drn, "drain1");
    applyStimulus(frz, "drain_freeze");
    applyStimulus(drn, "drain2");
    applyStimulus(drn, "drain3");
    applyStimulus(hltd, "halted_idle");
    applyStimulus(mk(0, 5, 1, 0, 5, 1, 0, 0, 1, 0, E_HLT, 1, 0, 0, 0), "halted_loaduse");
    applyStimulus(mk(0, 1, 2, 1, 3, 0, 1, 1, 0, 0, E_HLT, 1, 0, 0, 0), "halted_br_frz");
    checkCounters("halted");

    // Leave HALTED through reset, then abort a drain at dcnt=2.
    applyStimulus(mk(1, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RST, 1, 0, 0, 0), "rst_from_halted");
    applyStimulus(idle, "after_rst0");
    applyStimulus(halt, "halt_req2");
    applyStimulus(drn, "drain0b");
    applyStimulus(drn, "drain1b");
    applyStimulus(rstv, "rst_in_drain");
    applyStimulus(idle, "after_rst1");
    checkCounters("rst_in_drain");
    applyStimulus(idle, "run_confirm");

    // Memory timeout: fourth consecutive freeze stops the pipeline.
    for (int i = 0; i < 4; i++) applyStimulus(frz, $sformatf("timeout_frz%0d", i));
    applyStimulus(mk(0, 1, 2, 1, 3, 0, 0, 1, 0, 0, E_HLT, 1, 1, 0, 0), "timeout_halt");
    applyStimulus(mk(0, 1, 2, 1, 3, 0, 0, 1, 1, 0, E_HLT, 1, 1, 0, 0), "timeout_sticky");
    checkCounters("timeout");
    applyStimulus(mk(1, 1, 2, 1, 3, 0, 0, 0, 1, 0, E_RST, 1, 1, 0, 0), "timeout_rst");
    applyStimulus(idle, "timeout_cleared");
    checkCounters("timeout_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
